// File: rtl/store_narrow_unit_pkg.sv
// ============================================================================
// Module : store_narrow_unit_pkg
// Brief  : Shared size encodings, FSM state encoding and lane constants for
//          the store narrowing unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_narrow_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned c_DATA_WIDTH = 32;
  localparam int unsigned c_LANE_BITS  = 8;
  localparam int unsigned c_NUM_LANES  = c_DATA_WIDTH / c_LANE_BITS;

  function automatic logic is_narrow(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

  // Reserved size behaves as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SIZE_BYTE) return 1'b0;
    if (size == SIZE_HALF) return addr_lo[0];
    return addr_lo != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_narrow_unit_lane_merge.sv
// ============================================================================
// Module : lane_merge
// Brief  : Combinational little-endian merge of a byte/half/word store value
//          into an existing memory word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old_word;
    case (i_size)
      SIZE_BYTE: begin
        case (i_addr_lo)
          2'd0:    o_merged[7:0]   = i_data[7:0];
          2'd1:    o_merged[15:8]  = i_data[7:0];
          2'd2:    o_merged[23:16] = i_data[7:0];
          default: o_merged[31:24] = i_data[7:0];
        endcase
      end
      // Only addr[1] picks the half lane; addr[0] is ignored here.
      SIZE_HALF: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_data[15:0];
        else              o_merged[15:0]  = i_data[15:0];
      end
      default: o_merged = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_narrow_unit.sv
// ============================================================================
// Module : store_narrow_unit
// Brief  : Read-modify-write store unit narrowing a 32-bit value into a byte
//          or halfword lane. Optional misalignment trap: STORE_MISALIGN_TRAP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  input  logic [1:0]            size_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i
);

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [1:0]            r_size;
  logic [31:0]           r_wdata;
  logic [31:0]           w_merged;
  logic                  w_accept;
  logic                  w_trap;

  assign w_accept = (r_state == ST_IDLE) && req_i;

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_trap = is_misaligned(size_i, addr_i[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_trap;
  end
`else
  assign w_trap = 1'b0;
`endif

  lane_merge u_lane_merge (
    .i_old_word (mem_rdata_i),
    .i_data     (r_data),
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    ready_o      = 1'b0;
    done_o       = 1'b0;
    fault_o      = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          // A trapped store skips memory and uses DONE to report the fault.
          if (w_trap)                w_next_state = ST_DONE;
          else if (is_narrow(size_i)) w_next_state = ST_RD;
          else                       w_next_state = ST_WR;
        end
      end
      ST_RD: begin
        mem_rd_o = 1'b1;
        if (mem_ack_i) w_next_state = ST_WR;
      end
      ST_WR: begin
        mem_wr_o = 1'b1;
        if (mem_ack_i) w_next_state = ST_DONE;
      end
      ST_DONE: begin
`ifdef STORE_MISALIGN_TRAP_EN
        done_o  = !r_fault;
        fault_o = r_fault;
`else
        done_o  = 1'b1;
`endif
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= SIZE_BYTE;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= addr_i;
      r_data  <= data_i;
      r_size  <= size_i;
      r_wdata <= data_i;
    end else if ((r_state == ST_RD) && mem_ack_i) begin
      r_wdata <= w_merged;
    end
  end

  assign mem_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte address width; data path fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_i  input  1  store request; accepted only when ready_o=1.
REQ-005 addr_i  input  ADDR_WIDTH  byte address of store.
REQ-006 data_i  input  32  register value; low byte/half/word is stored.
REQ-007 size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 ready_o  output  1  high only in IDLE.
REQ-009 done_o  output  1  one-cycle pulse on store completion.
REQ-010 fault_o  output  1  one-cycle pulse on rejected misaligned store (see Configuration).
REQ-011 mem_addr_o  output  ADDR_WIDTH  word-aligned address (bits [1:0] = 00).
REQ-012 mem_rd_o / mem_wr_o  output  1 each  read / write strobes, held until mem_ack_i.
REQ-013 mem_wdata_o  output  32  merged word to write.
REQ-014 mem_rdata_i  input  32  read data, valid when mem_ack_i=1 during read.
REQ-015 mem_ack_i  input  1  memory completion for current strobe.

Function
REQ-016 Inverse of load-side sign/zero extension: narrows a 32-bit value into a byte or halfword lane of an existing memory word via read-modify-write.
REQ-017 FSM states IDLE, RD, WR, DONE; exactly one active.
REQ-018 IDLE: on req_i, latch addr_i, data_i, size_i; word -> WR, byte/half -> RD, next cycle.
REQ-019 RD: mem_rd_o=1; on mem_ack_i capture mem_rdata_i, merge, -> WR.
REQ-020 WR: mem_wr_o=1, mem_wdata_o stable; on mem_ack_i -> DONE.
REQ-021 DONE: done_o=1 for one cycle -> IDLE.
REQ-022 Lane select little-endian: byte lane = addr[1:0]; half lane = addr[1]; unselected bytes preserved from read word.
REQ-023 Word store: no read issued; mem_wdata_o = data_i.
REQ-024 Minimum latency with ack in the same cycle as strobe: word 2 cycles accept->done, byte/half 3 cycles.
REQ-025 req_i outside IDLE ignored; latched operands unaffected by input changes after accept.
REQ-026 mem_rd_o and mem_wr_o never high together; mem_ack_i in IDLE/DONE ignored.

Reset
REQ-027 reset forces IDLE immediately, including mid-RD/WR; strobe abandoned.
REQ-028 Reset values: ready_o=1, done_o=0, fault_o=0, mem_rd_o=0, mem_wr_o=0, mem_addr_o=0, mem_wdata_o=0.

Configuration
REQ-029 Macro STORE_MISALIGN_TRAP_EN.
REQ-030 Defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no memory access, fault_o pulses the cycle after accept, returns to IDLE, done_o stays 0.
REQ-031 Undefined: misaligned address bits ignored (half uses addr[1], word uses lane 0); fault_o tied 0.

Structure
REQ-032 Shared package: size encodings, FSM state encoding, lane constants.
REQ-033 One combinational sub-module lane_merge (old word, data, size, addr[1:0] -> merged word).

Verification
REQ-034 Mem[0x10]=0xAABBCCDD; byte 0x12345678 @0x11 -> one read, write 0xAABB78DD, done_o once.
REQ-035 Same word; half 0x12345678 @0x12 -> write 0x5678CCDD.
REQ-036 Word 0xDEADBEEF @0x20, ack same cycle -> no mem_rd_o, write 0xDEADBEEF, done_o 2 cycles after accept.
REQ-037 Half @0x13 with macro -> fault_o pulse, no strobes; without macro -> half written to upper lane.
REQ-038 reset asserted during RD with ack withheld -> all strobes 0 at once, ready_o=1; next store completes correctly.
REQ-039 req_i toggled during WR with ack delayed 5 cycles -> single write, latched data unchanged.
